booth_r2_seq_mult: RTL and testbench

Sequential radix-2 Booth multiplier core, instantiated inside the user project wrapper.
- Multiplicand/multiplier arrive from mprj_io input pads; product drives mprj_io output pads.
- Signed two's-complement operands, one Booth step per clock, start/done handshake.
- Default configuration is the 4-bit instance: operands on mprj_io[19:16] (M) and [23:20] (Q), product on [35:28].

---
 rtl/booth_r2_seq_mult_pkg.sv | 21 ++
 rtl/booth_r2_seq_mult_step.sv | 45 ++++
 rtl/booth_r2_seq_mult.sv | 122 ++++++++++++
 tb/tb_booth_r2_seq_mult.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/booth_r2_seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module  : booth_r2_seq_mult_pkg
// Brief   : Shared state encoding and default sizing for the radix-2 Booth
//           sequential multiplier.
// Revision: 1.0 - initial release
// ============================================================================
package booth_r2_seq_mult_pkg;

    // Default operand width of the pad-mapped instance.
    localparam int c_default_width = 4;

    // Controller state encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/booth_r2_seq_mult_step.sv
`default_nettype none
// ============================================================================
// Module  : booth_r2_step
// Brief   : One combinational radix-2 Booth iteration: conditional add/sub of
//           the sign-extended multiplicand into A, then arithmetic right shift
//           of {A,Q,q_1}.
// Revision: 1.0 - initial release
// ============================================================================
module booth_r2_step
    import booth_r2_seq_mult_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_q1,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH:0]   o_a,
    output logic [WIDTH-1:0] o_q,
    output logic             o_q1
);

    // A carries one guard bit so the most-negative multiplicand cannot overflow.
    logic [WIDTH:0] w_m_sext;
    logic [WIDTH:0] w_sum;

    assign w_m_sext = {i_m[WIDTH-1], i_m};

    // Booth recoding on the current multiplier LSB and the previously shifted-out bit.
    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q1})
            2'b01:   w_sum = i_a + w_m_sext;
            2'b10:   w_sum = i_a - w_m_sext;
            default: w_sum = i_a;
        endcase
    end

    // Arithmetic right shift of the concatenated {A,Q,q_1}.
    assign o_a  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign o_q  = {w_sum[0], i_q[WIDTH-1:1]};
    assign o_q1 = i_q[0];

endmodule
`default_nettype wire

// File: rtl/booth_r2_seq_mult.sv
`default_nettype none
// ============================================================================
// Module  : booth_r2_seq_mult
// Brief   : Sequential signed radix-2 Booth multiplier, one step per clock,
//           load/busy/done handshake, registered product output.
// Revision: 1.0 - initial release
// ============================================================================
module booth_r2_seq_mult
    import booth_r2_seq_mult_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CNT_W = 3                 // 2**CNT_W must exceed WIDTH
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 load,
    input  logic [WIDTH-1:0]     m_in,
    input  logic [WIDTH-1:0]     q_in,
    output logic [2*WIDTH-1:0]   p_out,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q,     m_d;
    logic [WIDTH:0]       a_q,     a_d;
    logic [WIDTH-1:0]     qr_q,    qr_d;
    logic                 q1_q,    q1_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [2*WIDTH-1:0]   p_q,     p_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;

    logic [WIDTH:0]       w_step_a;
    logic [WIDTH-1:0]     w_step_q;
    logic                 w_step_q1;

    booth_r2_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_a  (a_q),
        .i_q  (qr_q),
        .i_q1 (q1_q),
        .i_m  (m_q),
        .o_a  (w_step_a),
        .o_q  (w_step_q),
        .o_q1 (w_step_q1)
    );

    // Next-state logic: operand capture on launch, one Booth step per RUN cycle.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        a_d     = a_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    state_d = ST_RUN;
                    m_d     = m_in;
                    a_d     = '0;
                    qr_d    = q_in;
                    q1_d    = 1'b0;
                    cnt_d   = c_cnt_init;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d   = w_step_a;
                qr_d  = w_step_q;
                q1_d  = w_step_q1;
                cnt_d = cnt_q - c_cnt_one;
                if (cnt_q == c_cnt_one) begin
                    // Guard bit of A is dropped; the product fits in 2*WIDTH bits.
                    state_d = ST_DONE;
                    p_d     = {w_step_a[WIDTH-1:0], w_step_q};
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            a_q     <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign p_out = p_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_r2_seq_mult.sv
`default_nettype none
// ============================================================================
// Module  : tb_booth_r2_seq_mult
// Brief   : Directed, table-driven bench for the 4-bit Booth multiplier.
// Revision: 1.0 - initial release
// ============================================================================
module tb_booth_r2_seq_mult;

    logic       clock;
    logic       resetb;
    logic       load;
    logic [3:0] m_in;
    logic [3:0] q_in;
    logic [7:0] p_out;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] p;
    } vec_t;

    vec_t vecs [6];

    booth_r2_seq_mult #(
        .WIDTH (4),
        .CNT_W (3)
    ) dut (
        .clock  (clock),
        .resetb (resetb),
        .load   (load),
        .m_in   (m_in),
        .q_in   (q_in),
        .p_out  (p_out),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Launch one multiply and check its busy window, result and done pulse width.
    task automatic run_mult(input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp,
                            input bit check_busy);
        @(negedge clock);
        load = 1'b1;
        m_in = m;
        q_in = q;
        @(negedge clock);              // after edge k
        load = 1'b0;
        if (check_busy) check("busy_k", 16'(busy), 16'd1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clock);          // after edge k+i
            if (check_busy) check("busy_run", 16'(busy), 16'd1);
            if (check_busy) check("done_run", 16'(done), 16'd0);
        end
        @(negedge clock);              // after edge k+4
        check("done_pulse", 16'(done), 16'd1);
        check("p_out", 16'(p_out), 16'(exp));
        if (check_busy) check("busy_end", 16'(busy), 16'd0);
        @(negedge clock);
        check("done_width", 16'(done), 16'd0);
        if (check_busy) check("p_hold", 16'(p_out), 16'(exp));
    endtask

    initial begin
        int done_cnt;
        logic [7:0] exp_p;
        n_cmp    = 0;
        n_err    = 0;
        resetb   = 1'b0;
        load     = 1'b0;
        m_in     = '0;
        q_in     = '0;

        vecs[0] = '{m: 4'b1010, q: 4'b1011, p: 8'h1E};   // -6 x -5
        vecs[1] = '{m: 4'd7,    q: 4'd7,    p: 8'h31};   //  7 x  7
        vecs[2] = '{m: 4'b1000, q: 4'd7,    p: 8'hC8};   // -8 x  7
        vecs[3] = '{m: 4'b1000, q: 4'b1000, p: 8'h40};   // -8 x -8
        vecs[4] = '{m: 4'd0,    q: 4'b1111, p: 8'h00};   //  0 x -1
        vecs[5] = '{m: 4'd3,    q: 4'b1110, p: 8'hFA};   //  3 x -2

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_p_out", 16'(p_out), 16'h0);
        check("rst_busy",  16'(busy),  16'h0);
        check("rst_done",  16'(done),  16'h0);
        resetb = 1'b1;
        @(negedge clock);

        // Directed vector table
        for (int v = 0; v < 6; v++) begin
            run_mult(vecs[v].m, vecs[v].q, vecs[v].p, 1'b1);
        end

        // Load while busy is ignored
        @(negedge clock);
        load = 1'b1; m_in = 4'd3; q_in = 4'd2;
        @(negedge clock);              // after edge k
        load = 1'b0;
        @(negedge clock);              // after edge k+1
        load = 1'b1; m_in = 4'd5; q_in = 4'd5;
        @(negedge clock);              // after edge k+2
        load = 1'b0;
        @(negedge clock);              // after edge k+3
        @(negedge clock);              // after edge k+4
        check("ign_done", 16'(done), 16'd1);
        check("ign_p_out", 16'(p_out), 16'h06);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        check("ign_no_second", 16'(done_cnt), 16'd0);
        check("ign_p_hold", 16'(p_out), 16'h06);
        check("ign_idle_busy", 16'(busy), 16'd0);

        // load held high: result every 5 cycles
        @(negedge clock);
        load = 1'b1; m_in = 4'd3; q_in = 4'b1110;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);          // after edge k+i
            check("b2b_done", 16'(done), 16'((i % 5) == 4));
            if ((i % 5) == 4) check("b2b_p_out", 16'(p_out), 16'hFA);
        end
        load = 1'b0;
        repeat (6) @(negedge clock);

        // Asynchronous reset mid-RUN
        load = 1'b1; m_in = 4'b1010; q_in = 4'b1011;
        @(negedge clock);              // after edge k
        load = 1'b0;
        @(negedge clock);              // after edge k+1, second RUN cycle
        #2 resetb = 1'b0;
        #1;
        check("arst_p_out", 16'(p_out), 16'h0);
        check("arst_busy",  16'(busy),  16'h0);
        check("arst_done",  16'(done),  16'h0);
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        check("arst_no_done", 16'(done_cnt), 16'd0);
        run_mult(4'd2, 4'd3, 8'h06, 1'b1);

        // Exhaustive signed 4-bit sweep against a reference product
        for (int mi = -8; mi < 8; mi++) begin
            for (int qi = -8; qi < 8; qi++) begin
                exp_p = 8'(mi * qi);
                run_mult(4'(mi), 4'(qi), exp_p, 1'b0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
